// File: rtl/fp32_mul_result_buffer.sv
// Collection stage for the FP32 multiplier: captures every done beat into a FWFT FIFO,
// tracks in-flight multiplies for issue credit, and keeps sticky exception status.
module fp32_mul_result_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       issue_i,
    input  logic                       done_i,
    input  logic [WIDTH-1:0]           result_i,
    input  logic                       overflow_i,
    input  logic                       underflow_i,
    input  logic                       invalid_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [2:0]                 flags_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [$clog2(DEPTH+1)-1:0] inflight_o,
    output logic                       credit_ok_o,
    output logic [2:0]                 sticky_o,
    output logic [1:0]                 err_o,
    input  logic                       clear_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Handshake: a head beat transfers on any rising edge where valid_o && ready_i;
    // valid_o depends only on registered occupancy and data_o holds until that transfer.
    logic [WIDTH+2:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    inflight_q;
    logic [2:0]       sticky_q;
    logic [1:0]       err_q;

    logic       full;
    logic       pop;
    logic       push;
    logic       drop;
    logic       spurious;
    logic [2:0] beat_flags;
    logic [CW:0] occupancy;

    assign beat_flags = {invalid_i, underflow_i, overflow_i};
    assign full       = (count_q == CW'(DEPTH));
    assign pop        = valid_o && ready_i;
    assign push       = done_i && (!full || pop);
    assign drop       = done_i && !push;
    assign spurious   = done_i && !issue_i && (inflight_q == '0);

    // Storage is intentionally left unreset; only the bookkeeping below is cleared.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {beat_flags, result_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            sticky_q   <= '0;
            err_q      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            // Saturates at DEPTH on issue and floors at zero on a spurious done.
            if (issue_i && !done_i && (inflight_q != CW'(DEPTH))) begin
                inflight_q <= inflight_q + CW'(1);
            end else if (done_i && !issue_i && (inflight_q != '0)) begin
                inflight_q <= inflight_q - CW'(1);
            end
            sticky_q <= (clear_i ? 3'b000 : sticky_q) | (push ? beat_flags : 3'b000);
            err_q    <= (clear_i ? 2'b00 : err_q) | {spurious, drop};
        end
    end

    assign occupancy   = {1'b0, count_q} + {1'b0, inflight_q};
    assign credit_ok_o = (occupancy < (CW+1)'(DEPTH));
    assign valid_o     = (count_q != '0);
    assign data_o      = mem[rd_ptr][WIDTH-1:0];
    assign flags_o     = mem[rd_ptr][WIDTH+2:WIDTH];
    assign count_o     = count_q;
    assign inflight_o  = inflight_q;
    assign sticky_o    = sticky_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_fp32_mul_result_buffer.sv
// Randomized and directed bench for fp32_mul_result_buffer, checked every cycle
// against a queue-based reference model.
module tb_fp32_mul_result_buffer;
    localparam int DEPTH = 8;
    localparam int WIDTH = 32;
    localparam int LAT   = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             issue_i = 1'b0;
    logic             done_i = 1'b0;
    logic [WIDTH-1:0] result_i = '0;
    logic             overflow_i = 1'b0;
    logic             underflow_i = 1'b0;
    logic             invalid_i = 1'b0;
    logic             valid_o;
    logic             ready_i = 1'b0;
    logic [WIDTH-1:0] data_o;
    logic [2:0]       flags_o;
    logic [3:0]       count_o;
    logic [3:0]       inflight_o;
    logic             credit_ok_o;
    logic [2:0]       sticky_o;
    logic [1:0]       err_o;
    logic             clear_i = 1'b0;

    fp32_mul_result_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .issue_i(issue_i), .done_i(done_i),
        .result_i(result_i), .overflow_i(overflow_i), .underflow_i(underflow_i),
        .invalid_i(invalid_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .flags_o(flags_o), .count_o(count_o), .inflight_o(inflight_o),
        .credit_ok_o(credit_ok_o), .sticky_o(sticky_o), .err_o(err_o), .clear_i(clear_i)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    // reference model state
    logic [34:0] exp_q[$];
    int          m_infl;
    logic [2:0]  m_sticky;
    logic [1:0]  m_err;
    int          cyc;
    bit          chk_on;
    int          n_checks;
    int          n_fail;

    // multiplier model: results due LAT cycles after issue
    int          pend_due[$];
    logic [34:0] pend_beat[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit m_credit();
        return (exp_q.size() + m_infl) < DEPTH;
    endfunction

    task automatic model_step(input bit iss, dn, input logic [31:0] res, input logic [2:0] fl,
                              input bit rdy, clr, rst);
        bit pop, can, spur;
        if (rst) begin
            exp_q.delete();
            m_infl   = 0;
            m_sticky = '0;
            m_err    = '0;
        end else begin
            pop  = (exp_q.size() > 0) && rdy;
            can  = (exp_q.size() < DEPTH) || pop;
            spur = dn && !iss && (m_infl == 0);
            if (pop) void'(exp_q.pop_front());
            if (dn && can) exp_q.push_back({fl, res});
            if (iss && !dn && m_infl < DEPTH) m_infl++;
            else if (dn && !iss && m_infl > 0) m_infl--;
            m_sticky = (clr ? 3'b000 : m_sticky) | ((dn && can) ? fl : 3'b000);
            m_err    = (clr ? 2'b00 : m_err) | {spur, dn && !can};
        end
    endtask

    // driver: check current outputs at negedge, then apply one cycle of inputs
    task automatic drive(input bit iss, dn, input logic [31:0] res, input logic [2:0] fl,
                         input bit rdy, clr, rst);
        @(negedge clk_i);
        if (chk_on) begin
            check("valid", valid_o, exp_q.size() != 0);
            check("count", count_o, exp_q.size());
            check("inflight", inflight_o, m_infl);
            check("credit", credit_ok_o, m_credit());
            check("sticky", sticky_o, m_sticky);
            check("err", err_o, m_err);
            if (exp_q.size() > 0) begin
                check("data", data_o, exp_q[0][31:0]);
                check("flags", flags_o, exp_q[0][34:32]);
            end
        end
        issue_i     = iss;
        done_i      = dn;
        result_i    = res;
        overflow_i  = fl[0];
        underflow_i = fl[1];
        invalid_i   = fl[2];
        ready_i     = rdy;
        clear_i     = clr;
        rst_i       = rst;
        model_step(iss, dn, res, fl, rdy, clr, rst);
        cyc++;
    endtask

    task automatic mul_cycle(input bit iss, input logic [31:0] res, input logic [2:0] fl,
                             input bit rdy);
        bit          dn;
        logic [34:0] b;
        dn = 1'b0;
        b  = '0;
        if (iss) begin
            pend_due.push_back(cyc + LAT);
            pend_beat.push_back({fl, res});
        end
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            dn = 1'b1;
            b  = pend_beat.pop_front();
            void'(pend_due.pop_front());
        end
        drive(iss, dn, b[31:0], b[34:32], rdy, 1'b0, 1'b0);
    endtask

    task automatic mul_drain(input bit rdy);
        while (pend_due.size() > 0) mul_cycle(1'b0, '0, 3'b000, rdy);
    endtask

    task automatic after_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 3'b000, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        chk_on   = 0;
        m_infl   = 0;
        m_sticky = '0;
        m_err    = '0;

        drive(1'b0, 1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b1);
        chk_on = 1;
        after_edge();
        check("rst_valid", valid_o, 1'b0);
        check("rst_credit", credit_ok_o, 1'b1);

        // idle with ready asserted: nothing pops
        idle(10, 1'b1);

        // three multiplies, latency 4, consumer stalled
        mul_cycle(1'b1, 32'h4000_0000, 3'b000, 1'b0);
        mul_cycle(1'b1, 32'hC080_0000, 3'b000, 1'b0);
        mul_cycle(1'b1, 32'h40C0_0000, 3'b000, 1'b0);
        mul_drain(1'b0);
        idle(1, 1'b0);
        after_edge();
        check("three_count", count_o, 4'd3);
        check("three_head", data_o, 32'h4000_0000);
        idle(4, 1'b1);

        // back-to-back issue, honouring the credit
        while (m_credit()) mul_cycle(1'b1, $urandom, 3'b000, 1'b0);
        after_edge();
        check("credit_low", credit_ok_o, 1'b0);
        mul_drain(1'b0);
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 3'b000, 1'b0, 1'b0, 1'b0);
        after_edge();
        check("drop_err", err_o[0], 1'b1);
        check("drop_count", count_o, 4'd8);
        idle(9, 1'b1);

        // full FIFO streaming through pointer wrap
        for (int i = 0; i < DEPTH; i++)
            drive(1'b1, 1'b1, $urandom, 3'b000, 1'b0, i == 0, 1'b0);
        for (int i = 0; i < 20; i++)
            drive(1'b1, 1'b1, $urandom, 3'b000, 1'b1, 1'b0, 1'b0);
        after_edge();
        check("stream_noerr", err_o, 2'b00);
        idle(9, 1'b1);

        // sticky flags and clear/set priority
        drive(1'b1, 1'b1, 32'h7F80_0000, 3'b001, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 32'h7FC0_0000, 3'b100, 1'b1, 1'b0, 1'b0);
        after_edge();
        check("sticky_101", sticky_o, 3'b101);
        drive(1'b1, 1'b1, 32'h0000_0001, 3'b010, 1'b1, 1'b1, 1'b0);
        after_edge();
        check("sticky_010", sticky_o, 3'b010);
        idle(3, 1'b1);

        // spurious done still stored, then reset with stored beats
        drive(1'b0, 1'b1, 32'h1234_5678, 3'b000, 1'b0, 1'b1, 1'b0);
        after_edge();
        check("spur_err", err_o, 2'b10);
        check("spur_stored", count_o, 4'd1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, $urandom, 3'b000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b1);
        after_edge();
        check("rst_mid_valid", valid_o, 1'b0);
        check("rst_mid_count", count_o, 4'd0);
        idle(2, 1'b0);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 2) != 0, $urandom,
                  3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
        end
        idle(12, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp32_mul_result_buffer.md
# fp32_mul_result_buffer

Downstream collection stage for the FP32 multiplier. It captures every result/flag beat the multiplier emits on `done_o`, since the multiplier has no backpressure. Beats are held in a first-word-fall-through FIFO and presented to the consumer over a valid/ready handshake. The block also tracks in-flight multiplies so the issuer can throttle `valid_i` before the FIFO can overflow, and it keeps sticky IEEE exception status.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `WIDTH`, 32: result width.
- `clk_i`  in  1  sole clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `issue_i`  in  1  pulse per operand pair accepted by the multiplier (mirrors its `valid_i`).
- `done_i`  in  1  multiplier `done_o`.
- `result_i`  in  WIDTH  multiplier `result_o`.
- `overflow_i`, `underflow_i`, `invalid_i`  in  1 each  multiplier flags, qualified by `done_i`.
- `valid_o`  out  1  head entry available.
- `ready_i`  in  1  consumer accepts head.
- `data_o`  out  WIDTH  head result.
- `flags_o`  out  3  head flags {invalid, underflow, overflow}.
- `count_o`  out  $clog2(DEPTH+1)  occupied entries.
- `inflight_o`  out  $clog2(DEPTH+1)  issued, not yet done.
- `credit_ok_o`  out  1  issuer may assert `issue_i` this cycle.
- `sticky_o`  out  3  sticky {invalid, underflow, overflow}.
- `err_o`  out  2  sticky {spurious_done, drop}.
- `clear_i`  in  1  clears `sticky_o` and `err_o`.

## Operation
- Write: `done_i` pushes {flags, result_i} at `wr_ptr` if not full, or if full with a pop in the same cycle. Otherwise the beat is dropped and `err_o[0]` (drop) is set.
- Read: a pop occurs when `valid_o && ready_i`. `data_o`/`flags_o` = entry at `rd_ptr`, driven from storage (FWFT, no read latency). `valid_o = count_o != 0`.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count_o` updates as +1 (push only), −1 (pop only), or unchanged (both or neither).
- In-flight counter:
  - +1 on `issue_i` only, −1 on `done_i` only, unchanged on both.
  - `done_i` with `inflight_o==0` and no same-cycle `issue_i`: the counter stays at 0, `err_o[1]` (spurious_done) is set, and the beat is still written if there is space.
  - `issue_i` when `inflight_o==DEPTH`: the counter saturates.
- Credit: `credit_ok_o = (count_o + inflight_o) < DEPTH`. It is a function of registered state only, with no combinational path from `ready_i`/`done_i`/`issue_i`. Honouring `credit_ok_o` guarantees no drop.
- Sticky flags:
  - `sticky_o |= flags` of every written beat.
  - Dropped beats do not update `sticky_o`.
  - `clear_i` zeroes `sticky_o`/`err_o`. With a same-cycle set, the set wins (the bit ends at 1).
- Storage contents are not reset; only pointers, counters and sticky bits are.
- Reset mid-operation: all in-flight and stored beats are discarded. Any `done_i` arriving after reset for pre-reset issues is treated as spurious (err_o[1]).

## Timing
- Reset values: `valid_o=0`, `count_o=0`, `inflight_o=0`, `credit_ok_o=1`, `sticky_o=0`, `err_o=0`. `data_o`/`flags_o` are don't-care while `valid_o=0`.
- A beat written on edge N drives `valid_o=1` and `data_o` in cycle N+1. Minimum done-to-consumer latency is 1 cycle.
- Sustained throughput is one push and one pop per cycle. A full FIFO with `ready_i=1` accepts a new beat every cycle.
- `credit_ok_o` reflects edge-N updates in cycle N+1. An issuer sampling it combinationally may issue at most one beat per cycle.
- `ready_i` may toggle freely. Once `valid_o` is high, `data_o` holds until popped.

## Test plan
- Reset then idle: all outputs at reset values. Assert `ready_i=1` for 10 cycles -> no pops, `count_o=0`, `credit_ok_o=1`.
- Issue 3 ops (1.0×2.0, −2.0×2.0, 0.5×12.0) into a multiplier model with latency 4 and `ready_i=0` -> `inflight_o` goes 1,2,3 then back to 0. Then `ready_i=1` pops 40000000, C0800000, 40C00000 in order with `flags_o=0`.
- Back-to-back issue with `ready_i=0` -> `credit_ok_o` drops when `count_o+inflight_o==8`. Force one extra `done_i` -> `err_o[0]=1`, `count_o` stays 8. Drain -> 8 correct words.
- Full FIFO with `ready_i=1` and `done_i` every cycle for 20 cycles -> no drop, FIFO order preserved across pointer wrap.
- Beats with overflow (7F800000, flags 001) then invalid (7FC00000, flags 100) -> `sticky_o=101`. `clear_i` in the same cycle as an underflow beat -> `sticky_o=010`.
- `done_i` with `inflight_o=0` -> `err_o[1]=1`, beat stored. Assert `rst_i` with 4 stored beats -> `valid_o=0`, `count_o=0` the next cycle.
